spi_reg_master: RTL and testbench

//  SPI initiator for the team's register-access SPI responder (config/status register bank).

---
 rtl/spi_reg_master_if.sv | 36 +++
 rtl/spi_reg_master.sv | 215 +++++++++++++++++++++
 tb/tb_spi_reg_master.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_master_if.sv
// spi_reg_master_if
//  Request/response bus between a register-access client and spi_reg_master.
//  master modport: the client issuing frames (drives mode/start/rw/addr/wdata).
//  slave modport : spi_reg_master itself (drives busy/done/rdata).
//  Signals:
//    mode  [1:0]  {cpol, cpha}, sampled with an accepted start
//    start        request pulse, accepted only while the engine is idle
//    rw           1 = write, 0 = read
//    addr         register address carried in the command byte
//    wdata        data byte shifted out in the data phase
//    busy         frame in progress
//    done         one-cycle pulse at the end of a frame
//    rdata        data byte captured from miso on the last read
interface spi_reg_master_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int REG_WIDTH  = 8
);
  logic [1:0]            mode;
  logic                  start;
  logic                  rw;
  logic [ADDR_WIDTH-1:0] addr;
  logic [REG_WIDTH-1:0]  wdata;
  logic                  busy;
  logic                  done;
  logic [REG_WIDTH-1:0]  rdata;

  modport master (
    output mode, start, rw, addr, wdata,
    input  busy, done, rdata
  );

  modport slave (
    input  mode, start, rw, addr, wdata,
    output busy, done, rdata
  );
endinterface

// File: rtl/spi_reg_master.sv
// spi_reg_master
//  SPI initiator for the register-access SPI responder. Each accepted request
//  produces one frame: command byte {rw, addr} then the data byte, MSB first,
//  in any of the four CPOL/CPHA modes.
//  Ports:
//    clk       system clock, rising edge
//    rstb      asynchronous active-low reset
//    ena       0 freezes every register (pins and done hold)
//    bus       request/response bus (slave side of spi_reg_master_if)
//    spi_cs_n  chip select, active low
//    spi_clk   SPI clock
//    spi_mosi  serial data to the responder
//    spi_miso  serial data from the responder, sampled without a synchroniser
module spi_reg_master #(
  parameter int CLK_DIV    = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int REG_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 ena,
  spi_reg_master_if.slave      bus,
  output logic                 spi_cs_n,
  output logic                 spi_clk,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  localparam int FRAME_BITS = 1 + ADDR_WIDTH + REG_WIDTH;
  localparam int HALF_W     = $clog2(2 * FRAME_BITS);
  localparam logic [7:0]        DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * FRAME_BITS - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [7:0]            div_cnt_q, div_cnt_d;
  logic [HALF_W-1:0]     half_cnt_q, half_cnt_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [REG_WIDTH-1:0]  rx_q, rx_d;
  logic [REG_WIDTH-1:0]  rdata_q, rdata_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic                  rw_q, rw_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [FRAME_BITS-1:0] frame_w;
  logic                  div_end;
  logic [HALF_W-1:0]     edge_idx;
  logic                  edge_leading;
  logic                  toggle;

  assign frame_w = {bus.rw, bus.addr, bus.wdata};
  assign div_end = (div_cnt_q == DIV_LAST);

  // edge_idx numbers the spi_clk toggles of a frame 0..31: toggle 0 is issued
  // when SETUP ends, toggle k opens half-period k of SHIFT. Even toggles are
  // leading edges, odd ones trailing.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    half_cnt_d = half_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rdata_d    = rdata_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    rw_d       = rw_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = done_q;
    toggle     = 1'b0;
    edge_idx     = (state_q == ST_SETUP) ? '0 : half_cnt_q + HALF_W'(1);
    edge_leading = ~edge_idx[0];

    if (ena) begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          sclk_d = cpol_q;
          cs_n_d = 1'b1;
          if (bus.start) begin
            state_d   = ST_SETUP;
            div_cnt_d = '0;
            cpol_d    = bus.mode[1];
            cpha_d    = bus.mode[0];
            rw_d      = bus.rw;
            cs_n_d    = 1'b0;
            busy_d    = 1'b1;
            sclk_d    = bus.mode[1];
            rx_d      = '0;
            // cpha=0 needs bit15 on the wire before the first (sampling) edge.
            if (!bus.mode[0]) begin
              mosi_d = frame_w[FRAME_BITS-1];
              tx_d   = frame_w << 1;
            end else begin
              mosi_d = 1'b0;
              tx_d   = frame_w;
            end
          end
        end
        ST_SETUP: begin
          div_cnt_d = div_cnt_q + 8'd1;
          if (div_end) begin
            state_d    = ST_SHIFT;
            div_cnt_d  = '0;
            half_cnt_d = '0;
            toggle     = 1'b1;
          end
        end
        ST_SHIFT: begin
          div_cnt_d = div_cnt_q + 8'd1;
          if (div_end) begin
            div_cnt_d = '0;
            if (half_cnt_q == HALF_LAST) begin
              state_d = ST_HOLD;
            end else begin
              half_cnt_d = edge_idx;
              toggle     = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          div_cnt_d = div_cnt_q + 8'd1;
          if (div_end) begin
            state_d   = ST_GAP;
            div_cnt_d = '0;
            cs_n_d    = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            if (!rw_q) begin
              rdata_d = rx_q;
            end
          end
        end
        ST_GAP: begin
          div_cnt_d = div_cnt_q + 8'd1;
          if (div_end) begin
            state_d   = ST_IDLE;
            div_cnt_d = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // On each toggle either sample miso or advance mosi depending on cpha.
      // The receive register keeps only the most recent byte, so command-byte
      // samples fall out on their own. cpha=0 skips the shift after bit 0.
      if (toggle) begin
        sclk_d = ~sclk_q;
        if (cpha_q ? !edge_leading : edge_leading) begin
          rx_d = {rx_q[REG_WIDTH-2:0], spi_miso};
        end
        if (cpha_q ? edge_leading : (!edge_leading && edge_idx != HALF_LAST)) begin
          mosi_d = tx_q[FRAME_BITS-1];
          tx_d   = tx_q << 1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      half_cnt_q <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rdata_q    <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      rw_q       <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      half_cnt_q <= half_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rdata_q    <= rdata_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      rw_q       <= rw_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign spi_cs_n  = cs_n_q;
  assign spi_clk   = sclk_q;
  assign spi_mosi  = mosi_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// tb_spi_reg_master
//  Scoreboard bench for spi_reg_master. The driver pushes the expected result
//  of each frame (from a register-bank reference model) into a queue; a
//  monitor pops and compares whenever done pulses. A behavioural SPI responder
//  with its own register bank captures mosi and drives miso.
module tb_spi_reg_master;

  localparam int D         = 4;
  localparam int FRAME_CYC = 1 + 34 * D;

  logic clk = 1'b0;
  logic rstb;
  logic ena;
  logic spi_cs_n, spi_clk, spi_mosi;
  logic spi_miso;

  spi_reg_master_if bus ();

  spi_reg_master #(.CLK_DIV(D)) dut (
    .clk      (clk),
    .rstb     (rstb),
    .ena      (ena),
    .bus      (bus),
    .spi_cs_n (spi_cs_n),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    int         exp_cyc;
  } txn_t;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    int         rises;
    int         samples;
  } frame_t;

  txn_t       sb[$];
  frame_t     seen[$];
  logic [7:0] model_regs[128];
  logic [7:0] resp_regs[128];
  logic [7:0] model_rdata;
  logic [1:0] resp_mode;
  int         last_done_cyc;
  int         next_ok;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done seen with ena high closes exactly one frame.
  txn_t   mon_t;
  frame_t mon_f;
  always @(negedge clk) begin
    if (rstb === 1'b1 && ena && bus.done) begin
      last_done_cyc = cyc;
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_t = sb.pop_front();
        checkOutput("done_cycle", cyc, mon_t.exp_cyc);
        checkOutput("busy_at_done", bus.busy, 1'b0);
        checkOutput("cs_n_at_done", spi_cs_n, 1'b1);
        checkOutput("rdata", bus.rdata, mon_t.exp_rdata);
        if (seen.size() == 0) begin
          checkOutput("frame_missing", 32'd0, 32'd1);
        end else begin
          mon_f = seen.pop_front();
          checkOutput("mosi_cmd", mon_f.cmd, {mon_t.rw, mon_t.addr});
          checkOutput("mosi_data", mon_f.data, mon_t.wdata);
          checkOutput("sclk_rises", mon_f.rises, 16);
          checkOutput("resp_samples", mon_f.samples, 16);
        end
      end
    end
  end

  // Responder model: register bank, 8 junk bits during the command byte,
  // register contents during the data byte of reads, commit of writes after
  // the 16th sample.
  logic        r_prev_cs, r_prev_clk, r_lead, r_cpha;
  int          r_edge, r_nsamp, r_rises;
  logic [15:0] r_cap;
  logic [7:0]  r_cmd, r_junk, r_tx;

  function automatic logic resp_bit(input int j);
    if (j < 8) return r_junk[7-j];
    return r_tx[15-j];
  endfunction

  initial begin
    r_prev_cs  = 1'b1;
    r_prev_clk = 1'b0;
    spi_miso   = 1'b0;
    r_edge = 0; r_nsamp = 0; r_rises = 0;
    r_cap = '0; r_cmd = '0; r_junk = '0; r_tx = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rstb !== 1'b1) begin
        r_prev_cs = 1'b1;
      end else if (r_prev_cs && !spi_cs_n) begin
        r_edge  = 0;
        r_nsamp = 0;
        r_rises = 0;
        r_cap   = '0;
        r_cmd   = '0;
        r_tx    = '0;
        r_junk  = 8'($urandom);
        if (!resp_mode[0]) spi_miso = resp_bit(0);
      end else if (!spi_cs_n && spi_clk != r_prev_clk) begin
        if (spi_clk) r_rises++;
        r_lead = (r_edge % 2 == 0);
        r_cpha = resp_mode[0];
        if (r_cpha ? !r_lead : r_lead) begin
          r_cap = {r_cap[14:0], spi_mosi};
          r_nsamp++;
          if (r_nsamp == 8) begin
            r_cmd = r_cap[7:0];
            r_tx  = r_cmd[7] ? 8'($urandom) : resp_regs[r_cmd[6:0]];
          end
          if (r_nsamp == 16 && r_cmd[7]) resp_regs[r_cmd[6:0]] = r_cap[7:0];
        end
        if (r_cpha && r_lead) spi_miso = resp_bit(r_edge / 2);
        else if (!r_cpha && !r_lead && (r_edge + 1) / 2 < 16) spi_miso = resp_bit((r_edge + 1) / 2);
        r_edge++;
      end else if (!r_prev_cs && spi_cs_n) begin
        seen.push_back('{r_cap[15:8], r_cap[7:0], r_rises, r_nsamp});
      end
      r_prev_cs  = spi_cs_n;
      r_prev_clk = spi_clk;
    end
  end

  // Issues one frame at the earliest legal cycle, with optional ignored start
  // pokes during SHIFT/GAP and an optional ena stall mid-SHIFT. Entered and
  // left on a negedge.
  task automatic applyStimulus(input logic [1:0] mode, input logic rw, input logic [6:0] addr,
                               input logic [7:0] wdata, input int stall,
                               input bit poke_busy, input bit poke_gap);
    txn_t t;
    int   a;
    while (cyc < next_ok) @(negedge clk);
    bus.mode  = mode;
    bus.rw    = rw;
    bus.addr  = addr;
    bus.wdata = wdata;
    bus.start = 1'b1;
    resp_mode = mode;
    a = cyc;
    if (rw) begin
      model_regs[addr] = wdata;
    end else begin
      model_rdata = model_regs[addr];
    end
    t.rw = rw; t.addr = addr; t.wdata = wdata;
    t.exp_rdata = model_rdata;
    t.exp_cyc   = a + FRAME_CYC + stall;
    sb.push_back(t);
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("busy_after_accept", bus.busy, 1'b1);
    checkOutput("cs_n_after_accept", spi_cs_n, 1'b0);
    if (poke_busy) begin
      while (cyc < a + 10) @(negedge clk);
      bus.mode = 2'($urandom); bus.rw = ~rw; bus.addr = 7'($urandom); bus.wdata = 8'($urandom);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    if (stall > 0) begin
      while (cyc < a + 40) @(negedge clk);
      ena = 1'b0;
      repeat (stall) @(negedge clk);
      ena = 1'b1;
    end
    for (int i = 0; i < FRAME_CYC + stall + 50 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
      sb.delete();
      seen.delete();
      next_ok = cyc + 2 * FRAME_CYC;
    end else begin
      next_ok = last_done_cyc + D;
      if (poke_gap) begin
        while (cyc < last_done_cyc + 1) @(negedge clk);
        bus.mode = 2'($urandom); bus.rw = 1'b1; bus.addr = 7'($urandom); bus.wdata = 8'($urandom);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < last_done_cyc + D - 1) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end
    end
  endtask

  initial begin
    #(600_000);
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a;
    rstb = 1'b0;
    ena  = 1'b1;
    bus.start = 1'b0; bus.mode = 2'd0; bus.rw = 1'b0; bus.addr = '0; bus.wdata = '0;
    resp_mode   = 2'd0;
    model_rdata = 8'h00;
    last_done_cyc = 0;
    next_ok = 0;
    for (int i = 0; i < 128; i++) begin
      model_regs[i] = 8'($urandom);
      resp_regs[i]  = model_regs[i];
    end
    model_regs[1] = 8'hA5;
    resp_regs[1]  = 8'hA5;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_cs_n", spi_cs_n, 1'b1);
    checkOutput("rst_sclk", spi_clk, 1'b0);
    checkOutput("rst_mosi", spi_mosi, 1'b0);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_done", bus.done, 1'b0);
    checkOutput("rst_rdata", bus.rdata, 8'h00);
    rstb = 1'b1;
    repeat (2) @(negedge clk);
    next_ok = cyc;

    // Write, mode 0, addr 2 <- 0x3A (command byte 0x82, done 137 cycles later)
    applyStimulus(2'd0, 1'b1, 7'h02, 8'h3A, 0, 1'b0, 1'b0);
    checkOutput("resp_reg2", resp_regs[2], 8'h3A);

    // Read, mode 3, addr 1 -> 0xA5; clock idles high afterwards
    applyStimulus(2'd3, 1'b0, 7'h01, 8'h00, 0, 1'b0, 1'b0);
    checkOutput("idle_sclk_cpol1", spi_clk, 1'b1);

    // All four modes round-trip 0x5C
    for (int m = 0; m < 4; m++) begin
      applyStimulus(2'(m), 1'b1, 7'(8'h10 + m), 8'h5C, 0, 1'b0, 1'b0);
      applyStimulus(2'(m), 1'b0, 7'(8'h10 + m), 8'($urandom), 0, 1'b0, 1'b0);
    end

    // Starts during SHIFT and GAP are ignored; next start at done+CLK_DIV taken
    applyStimulus(2'd1, 1'b1, 7'h20, 8'hC3, 0, 1'b1, 1'b1);
    applyStimulus(2'd2, 1'b0, 7'h20, 8'h00, 0, 1'b0, 1'b0);

    // ena low for 20 cycles mid-SHIFT delays done by exactly 20
    applyStimulus(2'd0, 1'b0, 7'h02, 8'h77, 20, 1'b0, 1'b0);

    // Random traffic
    for (int n = 0; n < 20; n++) begin
      applyStimulus(2'($urandom), 1'($urandom), 7'($urandom_range(0, 15)), 8'($urandom),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 25)) : 0,
                    1'($urandom), 1'($urandom));
    end

    // Async reset at bit 7 of a write: abandoned, no done, no commit
    while (cyc < next_ok) @(negedge clk);
    bus.mode = 2'd0; bus.rw = 1'b1; bus.addr = 7'h05; bus.wdata = 8'hEE;
    resp_mode = 2'd0;
    bus.start = 1'b1;
    a = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < a + 1 + D + 14 * D) @(negedge clk);
    #2 rstb = 1'b0;
    #1;
    checkOutput("abort_cs_n", spi_cs_n, 1'b1);
    checkOutput("abort_sclk", spi_clk, 1'b0);
    checkOutput("abort_busy", bus.busy, 1'b0);
    checkOutput("abort_done", bus.done, 1'b0);
    checkOutput("abort_rdata", bus.rdata, 8'h00);
    model_rdata = 8'h00;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("abort_no_commit", resp_regs[5], model_regs[5]);
    next_ok = cyc;

    // Read back after the abort still works
    applyStimulus(2'd3, 1'b0, 7'h05, 8'h00, 0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
